read_operation: RTL and testbench
=================================

# read_operation

Read-side pointer and empty-flag controller for the asynchronous FIFO. It synchronizes the Gray-coded write pointer into the read domain and advances the binary/Gray read pointer on accepted reads. It produces the registered empty flag plus occupancy, almost-empty and underflow status. It sits opposite the write-pointer/full controller: its `rptr` feeds the write-domain synchronizer, and its `raddr` drives the dual-port RAM read address.

## Interface
- `SIZE`, 4, address width; FIFO depth is 2^SIZE, pointers are SIZE+1 bits.
- `SYNC_STAGES`, 2, flop stages in the write-to-read pointer synchronizer (≥2).
- `AE_LEVEL`, 2, almost-empty threshold; `ralmost_empty` is asserted while occupancy ≤ AE_LEVEL.

Ports:
- `rclk` in 1: read-domain clock; the only clock in this block.
- `rrst` in 1: synchronous, active-high reset.
- `wptr` in SIZE+1: Gray write pointer from the write domain (asynchronous to `rclk`).
- `rinc` in 1: read request.
- `rempty` out 1: FIFO empty, registered.
- `ralmost_empty` out 1: occupancy ≤ AE_LEVEL, registered.
- `raddr` out SIZE: RAM read address, equal to `rbin[SIZE-1:0]`.
- `rptr` out SIZE+1: registered Gray read pointer, sent to the write domain.
- `rq2_wptr` out SIZE+1: synchronized Gray write pointer, the final synchronizer stage.
- `rlevel` out SIZE+1: registered occupancy as seen by the read side, 0..2^SIZE.
- `runderflow` out 1: sticky; set when a read is attempted while empty.

## Operation
- Synchronizer: chain of SYNC_STAGES flops clocked by `rclk`. Stage 0 samples `wptr`. All stages reset to 0. No logic between stages.
- Accepted read: `rinc & ~rempty`.
- `rbin_next = rbin + accepted`, modulo 2^(SIZE+1). `rbin` is registered.
- Gray conversion: `rgray_next = (rbin_next >> 1) ^ rbin_next`, and `rptr <= rgray_next`.
- Empty: `rempty <= (rgray_next == rq2_wptr)`. Because it compares the next pointer, the flag asserts on the same edge as the last read, with no extra bubble.
- Gray-to-binary of `rq2_wptr`, combinational:
  - `wbin_s[SIZE] = g[SIZE]`
  - `wbin_s[i] = wbin_s[i+1] ^ g[i]`
- Level: `rlevel <= wbin_s - rbin_next`, modulo 2^(SIZE+1). It is consistent with `rempty`: `rlevel == 0` exactly when `rempty == 1`.
- Almost-empty: `ralmost_empty <= (wbin_s - rbin_next) <= AE_LEVEL`.
- Underflow: when `rinc & rempty`, set `runderflow` at the next edge. Pointers do not move. Only `rrst` clears it.
- Status is pessimistic: `rlevel` and `rempty` lag real writes by the synchronizer latency. They never report more data than is present.
- Wrap-around: `rbin` wraps from 2^(SIZE+1)-1 to 0. `rptr` changes exactly one bit per accepted read, including at wrap. The level subtraction stays correct across wrap.

## Timing
- Reset values (after the first `rclk` edge with `rrst=1`):
  - `rptr=0`, `raddr=0`, `rbin=0`, `rq2_wptr=0`, all sync stages 0
  - `rempty=1`, `ralmost_empty=1`, `rlevel=0`, `runderflow=0`
- Reset asserted mid-operation: all state returns to reset values on the next edge and any pending read is discarded. The write side must be reset in the same window.
- Write visibility: a `wptr` change sampled at edge N appears on `rq2_wptr` after edge N+SYNC_STAGES-1. `rempty`, `rlevel` and `ralmost_empty` update at edge N+SYNC_STAGES.
- Read latency:
  - `rinc` sampled high at edge N with `rempty=0` updates `raddr`, `rptr`, `rempty` and `rlevel` at edge N.
  - RAM data for the old `raddr` is valid before edge N.
  - Back-to-back reads are allowed every cycle.
- Write arrival and read in the same cycle: the level is computed from the new `wbin_s` and `rbin_next`. Both effects apply, with no lost update.
- `rinc` while `rempty=1`: ignored for pointer purposes; only `runderflow` reacts.

## Test plan
- Reset: drive `wptr=5'b01100`, assert `rrst` for 2 cycles. Required: every output holds its reset value. After release, `rq2_wptr=01100` after 2 edges, and on the next edge `rempty=0`, `rlevel=8`.
- Single word (SIZE=4, SYNC_STAGES=2, AE_LEVEL=2): change `wptr` from 00000 to 00001. Required: at the 2nd edge `rempty=0`, `rlevel=1`, `ralmost_empty=1`. Then pulse `rinc` for one cycle: `raddr=1`, `rptr=00001`, `rempty=1`, `rlevel=0`.
- Full drain: set `wptr=11000` (gray of 16). Required: `rlevel=16` and `ralmost_empty=0`. Then hold `rinc` for 16 cycles: `raddr` steps 0..15 then wraps to 0, `ralmost_empty` rises when `rlevel=2`, and `rempty` rises on the 16th read edge with `rptr=11000`.
- Underflow: hold `rinc=1` with `rempty=1` for 3 cycles. Required: `runderflow=1` from the first edge, `rptr` unchanged, and `runderflow` stays 1 until `rrst`.
- Wrap: run 40 single-word write/read pairs, advancing `wptr` by one Gray step each time. Required: `rbin` wraps past 31, every `rptr` transition is a single-bit change, and `rlevel` never exceeds 1.
- Mid-operation reset: with `rlevel=5`, assert `rrst` for 1 cycle together with `rinc=1`. Required: reset values on the next edge and no pointer advance.

Source files
------------

// File: rtl/read_operation.sv
`default_nettype none
// ============================================================================
// Module   : read_operation
// Purpose  : Async-FIFO read-side controller: write-pointer synchronizer,
//            binary/Gray read pointer, empty/almost-empty/level/underflow.
// Revision : 1.0 - initial release
// ============================================================================
module read_operation #(
    parameter int SIZE        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic            rclk,
    input  logic            rrst,
    input  logic [SIZE:0]   wptr,
    input  logic            rinc,
    output logic            rempty,
    output logic            ralmost_empty,
    output logic [SIZE-1:0] raddr,
    output logic [SIZE:0]   rptr,
    output logic [SIZE:0]   rq2_wptr,
    output logic [SIZE:0]   rlevel,
    output logic            runderflow
);

    localparam logic [SIZE:0] c_AE_LEVEL = (SIZE+1)'(AE_LEVEL);

    logic [SIZE:0] r_sync [SYNC_STAGES];
    logic [SIZE:0] r_bin;
    logic [SIZE:0] w_wbin;
    logic [SIZE:0] w_bin_next;
    logic [SIZE:0] w_gray_next;
    logic [SIZE:0] w_level;
    logic          w_accept;

    // Plain flop chain: no logic between stages so each bit settles independently.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= wptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign rq2_wptr = r_sync[SYNC_STAGES-1];

    // Binary bit i of a Gray code is the XOR of all Gray bits at or above i.
    genvar gi;
    generate
        for (gi = 0; gi <= SIZE; gi++) begin : g_g2b
            assign w_wbin[gi] = ^(rq2_wptr >> gi);
        end
    endgenerate

    assign w_accept    = rinc & ~rempty;
    assign w_bin_next  = r_bin + {{SIZE{1'b0}}, w_accept};
    assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;
    assign w_level     = w_wbin - w_bin_next;

    // Flags are computed from the next pointer so empty asserts on the last read edge.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_bin         <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rlevel        <= '0;
            runderflow    <= 1'b0;
        end else begin
            r_bin         <= w_bin_next;
            rptr          <= w_gray_next;
            rempty        <= (w_gray_next == rq2_wptr);
            ralmost_empty <= (w_level <= c_AE_LEVEL);
            rlevel        <= w_level;
            if (rinc && rempty) begin
                runderflow <= 1'b1;
            end
        end
    end

    assign raddr = r_bin[SIZE-1:0];

endmodule
`default_nettype wire

// File: tb/tb_read_operation.sv
`default_nettype none
// ============================================================================
// Module   : tb_read_operation
// Purpose  : Scoreboard bench for read_operation against a count-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_read_operation;

    localparam int SIZE        = 4;
    localparam int SYNC_STAGES = 2;
    localparam int AE_LEVEL    = 2;
    localparam int PMOD        = 1 << (SIZE + 1);
    localparam int DEPTH       = 1 << SIZE;

    logic            clk = 1'b0;
    logic            rrst = 1'b1;
    logic [SIZE:0]   wptr = '0;
    logic            rinc = 1'b0;
    logic            rempty;
    logic            ralmost_empty;
    logic [SIZE-1:0] raddr;
    logic [SIZE:0]   rptr;
    logic [SIZE:0]   rq2_wptr;
    logic [SIZE:0]   rlevel;
    logic            runderflow;

    read_operation #(
        .SIZE(SIZE), .SYNC_STAGES(SYNC_STAGES), .AE_LEVEL(AE_LEVEL)
    ) dut (
        .rclk(clk), .rrst(rrst), .wptr(wptr), .rinc(rinc),
        .rempty(rempty), .ralmost_empty(ralmost_empty), .raddr(raddr),
        .rptr(rptr), .rq2_wptr(rq2_wptr), .rlevel(rlevel),
        .runderflow(runderflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        int rptr, raddr, rq2, level;
        bit empty, almost, uf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: counts of words, not pointer encodings.
    int wcnt    = 0;
    int m_reads = 0;
    int m_sync[SYNC_STAGES];
    bit m_empty = 1'b1;
    bit m_uf    = 1'b0;

    function automatic int gray(input int v);
        int b;
        b = v % PMOD;
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Apply inputs for the next edge, predict the result, queue it after the edge.
    task automatic step(input bit rst, input bit inc);
        exp_t e;
        int   vis;
        bit   acc;
        rrst = rst;
        rinc = inc;
        wptr = (SIZE+1)'(gray(wcnt));
        e.rst = rst;
        if (rst) begin
            m_reads = 0;
            for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 0;
            m_empty = 1'b1;
            m_uf    = 1'b0;
            e.level = 0;
            e.almost = 1'b1;
        end else begin
            acc     = inc && !m_empty;
            m_uf    = m_uf || (inc && m_empty);
            m_reads = (m_reads + (acc ? 1 : 0)) % PMOD;
            vis     = m_sync[SYNC_STAGES-1];
            e.level = (vis - m_reads + PMOD) % PMOD;
            m_empty = (e.level == 0);
            e.almost = (e.level <= AE_LEVEL);
            for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = wcnt % PMOD;
        end
        e.empty = m_empty;
        e.uf    = m_uf;
        e.rptr  = gray(m_reads);
        e.raddr = m_reads % DEPTH;
        e.rq2   = gray(m_sync[SYNC_STAGES-1]);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every queued prediction half a cycle after its edge.
    initial begin : monitor
        exp_t e;
        int   prev_rptr;
        prev_rptr = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rempty",        int'(rempty),        int'(e.empty));
                chk("ralmost_empty", int'(ralmost_empty), int'(e.almost));
                chk("rlevel",        int'(rlevel),        e.level);
                chk("rptr",          int'(rptr),          e.rptr);
                chk("raddr",         int'(raddr),         e.raddr);
                chk("rq2_wptr",      int'(rq2_wptr),      e.rq2);
                chk("runderflow",    int'(runderflow),    int'(e.uf));
                if (!e.rst) begin
                    chk("rptr_one_bit_step", ($countones(rptr ^ (SIZE+1)'(prev_rptr)) <= 1) ? 1 : 0, 1);
                end
                prev_rptr = int'(rptr);
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 0;

        // Reset while write pointer already shows 8 words (gray 01100).
        wcnt = 8;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        // Clean restart, then a single word written and read.
        wcnt = 0;
        step(1'b1, 1'b0);
        wcnt = 1;
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Full FIFO, then drain back-to-back across the raddr wrap.
        wcnt = (m_reads + DEPTH) % PMOD;
        repeat (3) step(1'b0, 1'b0);
        repeat (DEPTH) step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Reads while empty set the sticky underflow.
        repeat (3) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // Single-word write/read pairs, enough to wrap the binary pointer.
        wcnt = 0;
        step(1'b1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            wcnt = (wcnt + 1) % PMOD;
            repeat (3) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end

        // Reset mid-operation with a read pending.
        wcnt = (wcnt + 5) % PMOD;
        repeat (3) step(1'b0, 1'b0);
        wcnt = 0;
        step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // Random traffic, occupancy kept within the FIFO depth.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                wcnt = 0;
                step(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                if (((wcnt - m_reads + PMOD) % PMOD) < DEPTH && $urandom_range(0, 1) == 1)
                    wcnt = (wcnt + 1) % PMOD;
                step(1'b0, 1'($urandom_range(0, 1)));
            end
        end

        rinc = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
